// File: rtl/fifo_burst_reader.sv
// Read-side burst master: drains an attached FIFO in full bursts of
// BURST_LENGTH words, or in a partial burst once data has waited
// timeout_cycles, presenting each word on a registered valid/ready
// stream with a last marker on the final word of the burst.
module fifo_burst_reader #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DEPTH_LOG2   = $clog2(DEPTH),
  parameter int unsigned BURST_LENGTH = 4,
  parameter int unsigned TIMER_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [TIMER_WIDTH-1:0] timeout_cycles,
  input  logic                   fifo_empty,
  input  logic [DEPTH_LOG2:0]    fifo_level,
  output logic                   fifo_read_enable,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] burst_count,
  output logic [COUNT_WIDTH-1:0] partial_count
);

  localparam int unsigned       LVL_W     = DEPTH_LOG2 + 1;
  // A burst can never be longer than the FIFO can hold.
  localparam int unsigned       BURST_EFF = (BURST_LENGTH > DEPTH) ? DEPTH : BURST_LENGTH;
  localparam logic [LVL_W-1:0]  BURST_LVL = LVL_W'(BURST_EFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [TIMER_WIDTH:0]   timer_inc;
  logic [LVL_W-1:0]       remaining_q, remaining_d;
  logic                   partial_q, partial_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   out_partial_q, out_partial_d;
  logic [COUNT_WIDTH-1:0] burst_count_q, burst_count_d;
  logic [COUNT_WIDTH-1:0] partial_count_q, partial_count_d;
  logic                   pop;

  assign timer_inc = {1'b0, timer_q} + (TIMER_WIDTH+1)'(1);

  // Next-state, pop decision, output register and statistics update.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    remaining_d     = remaining_q;
    partial_d       = partial_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_last_d      = out_last_q;
    out_partial_d   = out_partial_q;
    burst_count_d   = burst_count_q;
    partial_count_d = partial_count_q;
    pop             = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable && !fifo_empty) state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        if (!enable) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (fifo_level >= BURST_LVL) begin
          state_d     = BURST;
          remaining_d = BURST_LVL;
          partial_d   = 1'b0;
          timer_d     = '0;
        end else if ((timeout_cycles != '0) && (timer_inc >= {1'b0, timeout_cycles})) begin
          state_d     = BURST;
          remaining_d = fifo_level;
          partial_d   = 1'b1;
          timer_d     = '0;
        end
      end
      BURST: begin
        // Pop only when the output register is free or being drained now.
        pop = resetn && (remaining_q != '0) && (!out_valid_q || out_ready);
        if (pop) remaining_d = remaining_q - LVL_W'(1);
        if ((pop && (remaining_q == LVL_W'(1))) || (remaining_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (out_valid_q && out_ready) begin
      out_valid_d   = 1'b0;
      out_data_d    = '0;
      out_last_d    = 1'b0;
      out_partial_d = 1'b0;
      if (out_last_q) begin
        burst_count_d = burst_count_q + COUNT_WIDTH'(1);
        if (out_partial_q) partial_count_d = partial_count_q + COUNT_WIDTH'(1);
      end
    end

    // A refill in the same cycle as an accept takes precedence over the clear.
    if (pop) begin
      out_valid_d   = 1'b1;
      out_data_d    = fifo_read_data;
      out_last_d    = (remaining_q == LVL_W'(1));
      out_partial_d = partial_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      remaining_q     <= '0;
      partial_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_last_q      <= 1'b0;
      out_partial_q   <= 1'b0;
      burst_count_q   <= '0;
      partial_count_q <= '0;
    end else begin
      assert (!(pop && fifo_empty));
      state_q         <= state_d;
      timer_q         <= timer_d;
      remaining_q     <= remaining_d;
      partial_q       <= partial_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_last_q      <= out_last_d;
      out_partial_q   <= out_partial_d;
      burst_count_q   <= burst_count_d;
      partial_count_q <= partial_count_d;
    end
  end

  assign fifo_read_enable = pop;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_last         = out_last_q;
  assign busy             = (state_q != IDLE);
  assign burst_count      = burst_count_q;
  assign partial_count    = partial_count_q;

endmodule
